// File: rtl/q65_regbus_sequencer_if.sv
// Request and register-strobe bundle between the instruction decoder (master),
// q65_regbus_sequencer (slave) and the register file on the quasi6502 internal bus.
interface q65_regbus_sequencer_if #(
    parameter int NUM_REGS = 8,
    parameter int SRC_W    = 3
);
    logic                reqValid;
    logic                reqReady;
    logic [SRC_W-1:0]    reqSrc;
    logic [NUM_REGS-1:0] reqDst;
    logic [NUM_REGS-1:0] enableOut;
    logic [NUM_REGS-1:0] loadOut;
    logic                busyOut;
    logic                doneOut;
    logic                errorOut;

    modport master (
        output reqValid, reqSrc, reqDst,
        input  reqReady, enableOut, loadOut, busyOut, doneOut, errorOut
    );

    modport slave (
        input  reqValid, reqSrc, reqDst,
        output reqReady, enableOut, loadOut, busyOut, doneOut, errorOut
    );
endinterface

// File: rtl/q65_regbus_sequencer.sv
// Queues register-to-register moves and sequences one-hot bus drive plus load strobes.
// Build option Q65_SEQ_NOHOLD_EN drops the HOLD state (2-cycle transfers, done in LOAD).
module q65_regbus_sequencer #(
    parameter int NUM_REGS   = 8,
    parameter int SRC_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clkIn,
    input  logic                  resetIn,
    q65_regbus_sequencer_if.slave bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = SRC_W + NUM_REGS;

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, HOLD} state_t;

    logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [CNT_W-1:0]    count_next;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [SRC_W-1:0]    head_src;
    logic [NUM_REGS-1:0] head_dst;
    logic                req_src_legal;

    state_t              state_reg;
    state_t              state_next;
    logic [SRC_W-1:0]    src_reg;
    logic [SRC_W-1:0]    src_next;
    logic [NUM_REGS-1:0] dst_reg;
    logic [NUM_REGS-1:0] dst_next;

    logic [NUM_REGS-1:0] enable_reg;
    logic [NUM_REGS-1:0] enable_next;
    logic [NUM_REGS-1:0] load_reg;
    logic [NUM_REGS-1:0] load_next;
    logic                done_reg;
    logic                done_next;
    logic                busy_reg;
    logic                busy_next;
    logic                ready_reg;
    logic                ready_next;
    logic                error_reg;

    assign push          = bus.reqValid && ready_reg;
    assign fifo_empty    = (count_reg == '0);
    assign head_src      = fifo_mem[rd_ptr_reg][ENTRY_W-1 -: SRC_W];
    assign head_dst      = fifo_mem[rd_ptr_reg][NUM_REGS-1:0];
    assign req_src_legal = (int'(bus.reqSrc) < NUM_REGS);

    always_ff @(posedge clkIn) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {bus.reqSrc, bus.reqDst};
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // The transfer's src/dst are latched on pop so the FIFO slot can be refilled mid-transfer.
    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = DRIVE;
                    src_next   = head_src;
                    dst_next   = head_dst;
                end
            end
            DRIVE: begin
                state_next = LOAD;
            end
`ifdef Q65_SEQ_NOHOLD_EN
            LOAD: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = DRIVE;
                    src_next   = head_src;
                    dst_next   = head_dst;
                end else begin
                    state_next = IDLE;
                end
            end
`else
            LOAD: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = DRIVE;
                    src_next   = head_src;
                    dst_next   = head_dst;
                end else begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
        end
    end

    // Out-of-range sources match no line, so they drive nothing and the bus floats.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_enable
        assign enable_next[gi] = (state_next != IDLE) && (src_next == SRC_W'(gi));
    end

    assign load_next  = (state_next == LOAD) ? dst_next : '0;
    assign busy_next  = (state_next != IDLE) || (count_next != '0);
    assign ready_next = (count_next != CNT_W'(FIFO_DEPTH));
`ifdef Q65_SEQ_NOHOLD_EN
    assign done_next  = (state_next == LOAD);
`else
    assign done_next  = (state_next == HOLD);
`endif

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            enable_reg <= '0;
            load_reg   <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            ready_reg  <= 1'b1;
            error_reg  <= 1'b0;
        end else begin
            enable_reg <= enable_next;
            load_reg   <= load_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
            ready_reg  <= ready_next;
            if (push && !req_src_legal) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign bus.reqReady  = ready_reg;
    assign bus.enableOut = enable_reg;
    assign bus.loadOut   = load_reg;
    assign bus.doneOut   = done_reg;
    assign bus.busyOut   = busy_reg;
    assign bus.errorOut  = error_reg;
endmodule
